// File: rtl/pci_rr_arbiter.sv
// ---------------------------------------------------------------------------
// PciRrArbiter (module pci_rr_arbiter)
// Round-robin PCI bus arbiter for N_REQ masters. It senses bus idle from
// FRAME/IRDY, issues at most one registered grant at a time, revokes a grant
// that is not taken up within TIMEOUT cycles, and rotates priority after each
// bus ownership.
//
// Optional feature: define PCI_ARB_PARK_EN to park the grant on PARK_ID while
// the bus is idle and nobody requests.
//
// Ports
//   i_clk             rising-edge clock
//   i_reset           synchronous, active-high reset
//   i_req             per-master request, level, active-high
//   i_frame           bus FRAME active (active-high)
//   i_irdy            bus IRDY active (active-high)
//   o_gnt             one-hot-or-zero grant, registered
//   o_owner           index of current/last granted master, registered
//   o_bus_busy        high while a granted transaction owns the bus
//   o_timeout_pulse   one-cycle pulse when a grant is revoked by timeout
// ---------------------------------------------------------------------------
module pci_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16,
  parameter int PARK_ID = 0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic                     i_frame,
  input  logic                     i_irdy,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [$clog2(N_REQ)-1:0] o_owner,
  output logic                     o_bus_busy,
  output logic                     o_timeout_pulse
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [N_REQ-1:0] ONE_MASK  = N_REQ'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);

`ifdef PCI_ARB_PARK_EN
  localparam logic [IDX_W-1:0] PARK_IDX  = IDX_W'(PARK_ID);
  localparam logic [N_REQ-1:0] PARK_MASK = ONE_MASK << PARK_IDX;
`endif

`ifdef PCI_ARB_PARK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, BUSY = 2'd2, PARK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, BUSY = 2'd2} state_t;
`endif

  state_t             r_state, w_state;
  logic [N_REQ-1:0]   r_gnt, w_gnt;
  logic [IDX_W-1:0]   r_owner, w_owner;
  logic               r_busy, w_busy;
  logic               r_tp, w_tp;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [IDX_W-1:0]   r_ptr, w_ptr;

  logic               w_bus_idle;
  logic [IDX_W-1:0]   w_winner;
  logic               w_found;

  assign w_bus_idle = !i_frame && !i_irdy;

  // Winner search: the first requesting master after the last bus owner,
  // wrapping around, so the master that just used the bus is looked at last.
  always_comb begin : winnerSearch
    logic [IDX_W-1:0] idx;
    w_winner = '0;
    w_found  = 1'b0;
    idx      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDX_W'((int'(r_ptr) + i) % N_REQ);
      if (!w_found && i_req[idx]) begin
        w_winner = idx;
        w_found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic. Every output is registered, so this
  // block computes what the registers take on the coming edge. A grant is
  // only ever issued from IDLE, which guarantees a gnt=0 cycle between owners.
  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_owner = r_owner;
    w_busy  = r_busy;
    w_tp    = 1'b0;
    w_cnt   = r_cnt;
    w_ptr   = r_ptr;
    case (r_state)
      IDLE: begin
        w_gnt  = '0;
        w_busy = 1'b0;
        if (w_bus_idle) begin
          if (w_found) begin
            w_gnt   = ONE_MASK << w_winner;
            w_owner = w_winner;
            w_cnt   = '0;
            w_state = GRANT;
          end
`ifdef PCI_ARB_PARK_EN
          else begin
            w_gnt   = PARK_MASK;
            w_owner = PARK_IDX;
            w_state = PARK;
          end
`endif
        end
      end
      GRANT: begin
        // Frame wins over withdrawal and timeout in the same cycle.
        if (i_frame) begin
          w_ptr   = r_owner;
          w_busy  = 1'b1;
          w_state = BUSY;
        end else if (!i_req[r_owner]) begin
          w_gnt   = '0;
          w_state = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          // Timed-out master is moved to the back of the queue.
          w_gnt   = '0;
          w_tp    = 1'b1;
          w_ptr   = r_owner;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      BUSY: begin
        if (w_bus_idle) begin
          w_gnt   = '0;
          w_busy  = 1'b0;
          w_state = IDLE;
        end else if (!i_req[r_owner]) begin
          w_gnt = '0;
        end
      end
`ifdef PCI_ARB_PARK_EN
      PARK: begin
        if (i_frame) begin
          w_ptr   = PARK_IDX;
          w_busy  = 1'b1;
          w_state = BUSY;
        end else if ((i_req & ~PARK_MASK) != '0) begin
          w_gnt   = '0;
          w_state = IDLE;
        end
      end
`endif
      default: begin
        w_gnt   = '0;
        w_busy  = 1'b0;
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset. Reset drops any
  // grant on the same edge and never produces a timeout pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
      r_tp    <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= PTR_RESET;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_owner <= w_owner;
      r_busy  <= w_busy;
      r_tp    <= w_tp;
      r_cnt   <= w_cnt;
      r_ptr   <= w_ptr;
    end
  end

  assign o_gnt           = r_gnt;
  assign o_owner         = r_owner;
  assign o_bus_busy      = r_busy;
  assign o_timeout_pulse = r_tp;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pci_rr_arbiter
// Directed self-checking bench for pci_rr_arbiter (N_REQ=4, TIMEOUT=16).
// Expected grants, owners and pulses are hand-derived from the arbitration
// rules. Build with PCI_ARB_PARK_EN defined to cover the parking behaviour.
// ---------------------------------------------------------------------------
module tb_pci_rr_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       frame;
  logic       irdy;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busBusy;
  logic       timeoutPulse;

  int checkCount;
  int errorCount;

  pci_rr_arbiter #(
    .N_REQ  (4),
    .TIMEOUT(16),
    .PARK_ID(0)
  ) dut (
    .i_clk          (clock),
    .i_reset        (reset),
    .i_req          (req),
    .i_frame        (frame),
    .i_irdy         (irdy),
    .o_gnt          (gnt),
    .o_owner        (owner),
    .o_bus_busy     (busBusy),
    .o_timeout_pulse(timeoutPulse)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one set of inputs, let one rising edge sample them, then settle
  // 1 ns past the edge so outputs can be sampled away from the edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] r,
                               input logic f, input logic ir);
    reset = rst;
    req   = r;
    frame = f;
    irdy  = ir;
    @(posedge clock);
    #1;
  endtask

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Convenience wrapper comparing all four outputs.
  task automatic expectAll(input string tag, input logic [3:0] eGnt,
                           input logic [1:0] eOwner, input logic eBusy,
                           input logic eTp);
    checkOutput({tag, ".gnt"},     32'(gnt),          32'(eGnt));
    checkOutput({tag, ".owner"},   32'(owner),        32'(eOwner));
    checkOutput({tag, ".busy"},    32'(busBusy),      32'(eBusy));
    checkOutput({tag, ".timeout"}, 32'(timeoutPulse), 32'(eTp));
  endtask

  // Directed scenario sequence.
  initial begin
    int order [5];
    checkCount = 0;
    errorCount = 0;
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req   = 4'b1111;
    frame = 1'b0;
    irdy  = 1'b0;

    // Reset held two clocks with every master requesting.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    expectAll("reset1", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    expectAll("reset2", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Rotation: grant, frame two clocks later, bus goes idle, repeat.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      expectAll("rotGrant", 4'(1 << order[k]), 2'(order[k]), 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      checkOutput("rotWait.gnt", 32'(gnt), 32'(1 << order[k]));
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
      expectAll("rotBusy", 4'(1 << order[k]), 2'(order[k]), 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
      expectAll("rotHold", 4'(1 << order[k]), 2'(order[k]), 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      expectAll("rotRelease", 4'b0000, 2'(order[k]), 1'b0, 1'b0);
    end

    // Withdrawal: master 2 requests for three clocks and never drives frame.
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    expectAll("wdGrant", 4'b0100, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    checkOutput("wdHold1.gnt", 32'(gnt), 32'h4);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    checkOutput("wdHold2.gnt", 32'(gnt), 32'h4);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    expectAll("wdDrop", 4'b0000, 2'd2, 1'b0, 1'b0);
    // Pointer still at 0, so master 2 beats master 0.
    applyStimulus(1'b0, 4'b0101, 1'b0, 1'b0);
    expectAll("wdNoAdvance", 4'b0100, 2'd2, 1'b0, 1'b0);

    // Reset while granted: grant drops, no timeout pulse.
    applyStimulus(1'b1, 4'b0101, 1'b0, 1'b0);
    expectAll("resetMidGrant", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout: master 0 holds the grant 16 clocks without frame.
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0);
    expectAll("toGrant", 4'b0001, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0);
      checkOutput("toHold.gnt", 32'(gnt), 32'h1);
      checkOutput("toHold.timeout", 32'(timeoutPulse), 32'h0);
    end
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0);
    expectAll("toPulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0);
    expectAll("toNext", 4'b0010, 2'd1, 1'b0, 1'b0);

    // Frame arrives on the very cycle the counter would time out.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0);
      checkOutput("simWait.gnt", 32'(gnt), 32'h2);
    end
    applyStimulus(1'b0, 4'b0011, 1'b1, 1'b0);
    expectAll("simFrame", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Busy hold: owner withdraws, master 2 waits for a truly idle bus.
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0);
    expectAll("busyDrop", 4'b0000, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1);
    expectAll("busyFrameIrdy", 4'b0000, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b1);
    expectAll("busyIrdyTail", 4'b0000, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    expectAll("busyEnd", 4'b0000, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    expectAll("busyNextGrant", 4'b0100, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    expectAll("busyWithdraw", 4'b0000, 2'd2, 1'b0, 1'b0);

`ifdef PCI_ARB_PARK_EN
    // Parking on master 0, then master 3 takes over through a gnt=0 cycle.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    expectAll("parkEnter", 4'b0001, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
    expectAll("parkStay", 4'b0001, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);
    checkOutput("parkLeave.gnt", 32'(gnt), 32'h0);
    applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);
    expectAll("parkNext", 4'b1000, 2'd3, 1'b0, 1'b0);
`else
    // Without parking the grant stays low while nobody requests.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    expectAll("noParkIdle1", 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    expectAll("noParkIdle2", 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);
    expectAll("noParkNext", 4'b1000, 2'd3, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
